ram_arbiter: RTL and testbench

Two-requester arbiter for the single-port 256x16 synchronous RAM. It lets the CPU (requester 0) and a loader/debug port (requester 1) share the one RAM address/write port. Arbitration is round-robin per cycle, with an optional bounded lock so a requester can hold the RAM for a multi-cycle sequence (e.g. LDR/STR address-then-access). The block sits between the requesters and the RAM instance, replacing the direct CPU-to-RAM connection at the top level.

---
 rtl/ram_arbiter.sv | 159 +++++++++++++++
 tb/tb_ram_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the CPU (0) and a
// loader/debug port (1), with a bounded lock for multi-cycle sequences.
module ram_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_w_data,
  input  logic [DATA_W-1:0] ram_r_data,
  output logic              owner,
  output logic              busy
);

  // state   | meaning
  // IDLE    | round-robin per cycle, winner may take the lock
  // LOCK    | only owner may be granted; lock_cnt counts its grants
  // RELEASE | one-cycle forced handoff, non-owner has priority
  typedef enum logic [1:0] {IDLE, LOCK, RELEASE} state_t;

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  state_t           state;
  logic             last;
  logic [CNT_W-1:0] lock_cnt;

  logic win_valid;
  logic win;
  logic win_lock;
  logic own_lock;
  logic sel;

  always_comb begin
    win_valid = 1'b0;
    win       = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req0 && req1) begin
            win_valid = 1'b1;
            win       = ~last;
          end else if (req0) begin
            win_valid = 1'b1;
            win       = 1'b0;
          end else if (req1) begin
            win_valid = 1'b1;
            win       = 1'b1;
          end
        end
        LOCK: begin
          win       = owner;
          win_valid = owner ? req1 : req0;
        end
        RELEASE: begin
          if (owner ? req0 : req1) begin
            win_valid = 1'b1;
            win       = ~owner;
          end else begin
            win       = owner;
            win_valid = owner ? req1 : req0;
          end
        end
        default: begin
          win_valid = 1'b0;
          win       = 1'b0;
        end
      endcase
    end
  end

  assign gnt0     = win_valid & ~win;
  assign gnt1     = win_valid & win;
  assign win_lock = win ? lock1 : lock0;
  assign own_lock = owner ? lock1 : lock0;

  // Idle cycles keep the bus parked on the last winner to avoid needless toggling.
  assign sel        = win_valid ? win : last;
  assign ram_addr   = sel ? addr1 : addr0;
  assign ram_w_data = sel ? wdata1 : wdata0;
  assign ram_w_en   = win_valid & (win ? we1 : we0);

  assign rdata0 = ram_r_data;
  assign rdata1 = ram_r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      lock_cnt <= '0;
      owner    <= 1'b0;
      busy     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (win_valid) last <= win;
      case (state)
        IDLE: begin
          if (win_valid && win_lock) begin
            state    <= LOCK;
            owner    <= win;
            lock_cnt <= CNT_W'(1);
            busy     <= 1'b1;
          end
        end
        LOCK: begin
          if (!own_lock) begin
            state    <= IDLE;
            lock_cnt <= '0;
            busy     <= 1'b0;
          end else if (lock_cnt == CNT_W'(MAX_LOCK)) begin
            state <= RELEASE;
            busy  <= 1'b0;
          end else if (win_valid) begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        RELEASE: begin
          // A non-owner taking the RAM here may lock straight away; the old owner may not.
          if (win_valid && (win != owner) && win_lock) begin
            state    <= LOCK;
            owner    <= win;
            lock_cnt <= CNT_W'(1);
            busy     <= 1'b1;
          end else begin
            state    <= IDLE;
            lock_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          lock_cnt <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 256x16 synchronous RAM.
module tb_ram_arbiter;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 16;
  localparam int MAX_LOCK = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, req1, we0, we1, lock0, lock1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              ram_w_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_w_data;
  logic [DATA_W-1:0] ram_r_data;
  logic              owner, busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] mem [0:255];

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_w_en(ram_w_en), .ram_addr(ram_addr), .ram_w_data(ram_w_data),
    .ram_r_data(ram_r_data), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_w_en) mem[ram_addr] <= ram_w_data;
    ram_r_data <= mem[ram_addr];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
  endtask

  task automatic test_reset();
    req0 = 1; we0 = 1; lock0 = 1; req1 = 1; addr1 = 8'h77;
    #1;
    n_checks++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt0 got %b want 0", gnt0); end
    n_checks++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt1 got %b want 0", gnt1); end
    n_checks++; if (ram_w_en !== 1'b0) begin n_fail++; $display("FAIL reset_w_en got %b want 0", ram_w_en); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (owner !== 1'b0) begin n_fail++; $display("FAIL reset_owner got %b want 0", owner); end
    n_checks++; if ({rvalid0, rvalid1} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got %b want 00", {rvalid0, rvalid1}); end
    n_checks++; if (ram_addr !== 8'h77) begin n_fail++; $display("FAIL reset_park_last got %h want 77", ram_addr); end
    clear_inputs();
    rst = 0;
    next_cycle();
  endtask

  task automatic test_tie();
    logic exp_g0, exp_rv0, exp_rv1;
    logic [ADDR_W-1:0] exp_addr;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 8'h10; addr1 = 8'h20;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_g0   = (k % 2 == 0);
      exp_addr = exp_g0 ? 8'h10 : 8'h20;
      exp_rv0  = (k % 2 == 1);
      exp_rv1  = (k == 2);
      n_checks++; if ({gnt0, gnt1} !== {exp_g0, ~exp_g0}) begin n_fail++; $display("FAIL tie_gnt[%0d] got %b%b want %b%b", k, gnt0, gnt1, exp_g0, ~exp_g0); end
      n_checks++; if (ram_addr !== exp_addr) begin n_fail++; $display("FAIL tie_addr[%0d] got %h want %h", k, ram_addr, exp_addr); end
      n_checks++; if ({rvalid0, rvalid1} !== {exp_rv0, exp_rv1}) begin n_fail++; $display("FAIL tie_rvalid[%0d] got %b%b want %b%b", k, rvalid0, rvalid1, exp_rv0, exp_rv1); end
      if (k == 1) begin
        n_checks++; if (rdata0 !== 16'hA010) begin n_fail++; $display("FAIL tie_rdata0 got %h want a010", rdata0); end
      end
      if (k == 2) begin
        n_checks++; if (rdata1 !== 16'hA020) begin n_fail++; $display("FAIL tie_rdata1 got %h want a020", rdata1); end
      end
      next_cycle();
    end
    clear_inputs();
    #1;
    n_checks++; if ({rvalid0, rvalid1} !== 2'b01) begin n_fail++; $display("FAIL tie_last_rvalid got %b%b want 01", rvalid0, rvalid1); end
    n_checks++; if (ram_addr !== 8'h20) begin n_fail++; $display("FAIL tie_park got %h want 20", ram_addr); end
    next_cycle();
  endtask

  task automatic test_handoff();
    req1 = 1; we1 = 1; addr1 = 8'h05; wdata1 = 16'hBEEF;
    #1;
    n_checks++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL wr_gnt1 got %b want 1", gnt1); end
    n_checks++; if ({ram_w_en, ram_addr, ram_w_data} !== {1'b1, 8'h05, 16'hBEEF}) begin n_fail++; $display("FAIL wr_bus got %b %h %h want 1 05 beef", ram_w_en, ram_addr, ram_w_data); end
    next_cycle();
    req1 = 0; we1 = 0; req0 = 1; we0 = 0; addr0 = 8'h05;
    #1;
    n_checks++; if ({gnt0, ram_w_en, rvalid1} !== 3'b100) begin n_fail++; $display("FAIL rd_gnt0 got gnt0=%b w_en=%b rvalid1=%b want 1 0 0", gnt0, ram_w_en, rvalid1); end
    next_cycle();
    req0 = 0;
    #1;
    n_checks++; if (rvalid0 !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid0 got %b want 1", rvalid0); end
    n_checks++; if (rdata0 !== 16'hBEEF) begin n_fail++; $display("FAIL rd_rdata0 got %h want beef", rdata0); end
    next_cycle();
  endtask

  task automatic test_lock_release();
    req0 = 1; lock0 = 1; addr0 = 8'h40; addr1 = 8'h50;
    #1;
    n_checks++; if ({gnt0, busy} !== 2'b10) begin n_fail++; $display("FAIL lk_enter got gnt0=%b busy=%b want 1 0", gnt0, busy); end
    next_cycle();
    req1 = 1;
    for (int k = 1; k <= MAX_LOCK; k++) begin
      #1;
      n_checks++; if ({gnt0, gnt1, busy, owner} !== 4'b1010) begin n_fail++; $display("FAIL lk_hold[%0d] got gnt=%b%b busy=%b owner=%b want 10 1 0", k, gnt0, gnt1, busy, owner); end
      next_cycle();
    end
    #1;
    n_checks++; if ({gnt0, gnt1, busy} !== 3'b010) begin n_fail++; $display("FAIL lk_release got gnt=%b%b busy=%b want 01 0", gnt0, gnt1, busy); end
    n_checks++; if (ram_addr !== 8'h50) begin n_fail++; $display("FAIL lk_release_addr got %h want 50", ram_addr); end
    next_cycle();
    lock0 = 0;
    #1;
    n_checks++; if ({gnt0, gnt1, busy} !== 3'b100) begin n_fail++; $display("FAIL lk_rr0 got gnt=%b%b busy=%b want 10 0", gnt0, gnt1, busy); end
    next_cycle();
    #1;
    n_checks++; if ({gnt0, gnt1} !== 2'b01) begin n_fail++; $display("FAIL lk_rr1 got %b%b want 01", gnt0, gnt1); end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_unlock();
    req0 = 1; lock0 = 1;
    #1;
    n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL ul_first got %b want 1", gnt0); end
    next_cycle();
    req1 = 1;
    #1;
    n_checks++; if ({gnt0, gnt1, busy} !== 3'b101) begin n_fail++; $display("FAIL ul_second got gnt=%b%b busy=%b want 10 1", gnt0, gnt1, busy); end
    next_cycle();
    req0 = 0;
    #1;
    n_checks++; if ({gnt0, gnt1, ram_w_en, busy} !== 4'b0001) begin n_fail++; $display("FAIL ul_owner_idle got gnt=%b%b w_en=%b busy=%b want 00 0 1", gnt0, gnt1, ram_w_en, busy); end
    next_cycle();
    req0 = 1;
    #1;
    n_checks++; if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL ul_third got %b%b want 10", gnt0, gnt1); end
    next_cycle();
    lock0 = 0;
    #1;
    n_checks++; if ({gnt0, gnt1, busy} !== 3'b101) begin n_fail++; $display("FAIL ul_drop got gnt=%b%b busy=%b want 10 1", gnt0, gnt1, busy); end
    next_cycle();
    #1;
    n_checks++; if ({gnt0, gnt1, busy} !== 3'b010) begin n_fail++; $display("FAIL ul_pending got gnt=%b%b busy=%b want 01 0", gnt0, gnt1, busy); end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_lock();
    req0 = 1; lock0 = 1; we0 = 1; addr0 = 8'h30; wdata0 = 16'h1234;
    #1;
    n_checks++; if ({gnt0, ram_w_en} !== 2'b11) begin n_fail++; $display("FAIL rml_write got gnt0=%b w_en=%b want 1 1", gnt0, ram_w_en); end
    next_cycle();
    wdata0 = 16'h5555;
    #1;
    n_checks++; if ({busy, gnt0, ram_w_en} !== 3'b111) begin n_fail++; $display("FAIL rml_locked got busy=%b gnt0=%b w_en=%b want 1 1 1", busy, gnt0, ram_w_en); end
    rst = 1;
    #1;
    n_checks++; if ({busy, gnt0, gnt1, ram_w_en, owner, rvalid0, rvalid1} !== 7'b0) begin n_fail++; $display("FAIL rml_async got busy=%b gnt=%b%b w_en=%b owner=%b rvalid=%b%b want all 0", busy, gnt0, gnt1, ram_w_en, owner, rvalid0, rvalid1); end
    next_cycle();
    n_checks++; if (mem[8'h30] !== 16'h1234) begin n_fail++; $display("FAIL rml_no_write got %h want 1234", mem[8'h30]); end
    clear_inputs();
    req1 = 1; addr1 = 8'h30;
    rst = 0;
    #1;
    n_checks++; if ({gnt0, gnt1, busy} !== 3'b010) begin n_fail++; $display("FAIL rml_after got gnt=%b%b busy=%b want 01 0", gnt0, gnt1, busy); end
    next_cycle();
    req1 = 0;
    #1;
    n_checks++; if ({rvalid1, rdata1} !== {1'b1, 16'h1234}) begin n_fail++; $display("FAIL rml_read got rvalid1=%b rdata1=%h want 1 1234", rvalid1, rdata1); end
    next_cycle();
  endtask

  task automatic test_idle();
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if ({gnt0, gnt1, ram_w_en, rvalid0, rvalid1} !== 5'b0) begin n_fail++; $display("FAIL idle[%0d] got gnt=%b%b w_en=%b rvalid=%b%b want 0", k, gnt0, gnt1, ram_w_en, rvalid0, rvalid1); end
      n_checks++; if (ram_addr !== 8'h30) begin n_fail++; $display("FAIL idle_park[%0d] got %h want 30", k, ram_addr); end
      next_cycle();
    end
    req0 = 1; req1 = 1;
    #1;
    n_checks++; if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL idle_then_tie got %b%b want 10", gnt0, gnt1); end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    rst = 1;
    clear_inputs();
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_tie();
    test_handoff();
    test_lock_release();
    test_unlock();
    test_reset_mid_lock();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
